wb_stage: RTL

MEM/WB pipeline register and writeback controller that drives the write port of the register file: `wb_addr`, `wb_en`, `wb_data` and `wb_jal`. It accepts one retiring instruction per cycle through a valid/ready handshake. It selects the writeback value (ALU result, load data, or PC+4 link), suppresses writes to $0, and holds its entry while the register file port is blocked. It also exposes a bypass path for the forwarding unit and a retired-instruction counter.

---
 rtl/wb_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register driving the register-file write port,
// with a forwarding bypass and a retired-instruction counter.
module wb_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_regwrite,
    input  logic              in_jal,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic              flush,
    input  logic              rf_hold,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic              wb_jal,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retire_cnt
);
    logic              r_full;
    logic              r_regwrite;
    logic              r_jal;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_retire_cnt;
    logic              w_drain;
    logic              w_accept;
    logic              w_nonzero;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [DATA_W-1:0] w_cap_data;

    always_comb begin
        w_drain    = r_full & ~rf_hold;
        in_ready   = ~r_full | ~rf_hold;
        w_accept   = in_valid & in_ready & ~flush;
        w_nonzero  = |r_addr;
        // JAL overrides the destination and value regardless of select
        w_cap_addr = in_jal ? ADDR_W'(LINK_REG) : in_rd;
        w_cap_data = (in_jal || in_sel == 2'd2) ? in_pc4 :
                     (in_sel == 2'd1)           ? in_mem : in_alu;
        wb_en      = w_drain & r_regwrite & w_nonzero & ~flush;
        wb_jal     = r_jal & wb_en;
        wb_addr    = r_addr;
        wb_data    = r_data;
        fwd_valid  = r_full & r_regwrite & w_nonzero;
        fwd_addr   = r_addr;
        fwd_data   = r_data;
        retire_cnt = r_retire_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= 1'b0;
            r_regwrite   <= 1'b0;
            r_jal        <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_full <= flush ? 1'b0 : w_accept ? 1'b1 : w_drain ? 1'b0 : r_full;
            if (w_accept) begin
                r_addr     <= w_cap_addr;
                r_data     <= w_cap_data;
                r_regwrite <= in_jal | in_regwrite;
                r_jal      <= in_jal;
            end
            if (w_drain && !flush)
                r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end
endmodule
